// File: rtl/coax_ctrl_pkg.sv
// coax_ctrl_pkg: shared types and defaults for the coax transfer controller
package coax_ctrl_pkg;
    localparam int WORD_WIDTH           = 10;
    localparam int DEF_FIFO_DEPTH       = 16;
    localparam int DEF_RESPONSE_TIMEOUT = 1100;
    typedef enum logic [2:0] {IDLE, TX_LOAD, TX_DRAIN, RX_WAIT, RX_RECV, DONE} state_e;
endpackage

// File: rtl/coax_word_fifo.sv
// coax_word_fifo: synchronous first-word-fall-through word FIFO
module coax_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;
    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign rdata = mem_q[rptr_q];
    // pointers and occupancy; a same-cycle pop frees the slot a push needs when full
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end
    // word storage, no reset needed since reads are only meaningful when not empty
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/coax_xfer_ctrl.sv
// coax_xfer_ctrl: sequences a host command frame out to coax_tx and collects the coax_rx response
module coax_xfer_ctrl
    import coax_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
    parameter int RESPONSE_TIMEOUT = DEF_RESPONSE_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_tx_wr,
    input  logic [WORD_WIDTH-1:0] host_tx_wdata,
    output logic                  host_tx_full,
    input  logic                  host_start,
    input  logic                  host_rx_rd,
    output logic [WORD_WIDTH-1:0] host_rx_rdata,
    output logic                  host_rx_empty,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  overflow,
    output logic                  empty_start,
    output logic                  tx_load,
    output logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_full,
    input  logic                  tx_active,
    input  logic                  rx_active,
    input  logic [WORD_WIDTH-1:0] rx_data,
    input  logic                  rx_data_available,
    output logic                  rx_data_read
);
    localparam int CW = $clog2(RESPONSE_TIMEOUT + 1);
    state_e                state_q, state_d;
    logic                  seen_q, seen_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  load_prev_q, rd_prev_q;
    logic                  timeout_q, timeout_d, overflow_q, overflow_d, empty_start_q, empty_start_d;
    logic                  rx_clr, rx_push, tx_empty, rx_full;
    logic [WORD_WIDTH-1:0] tx_head;
    assign busy        = !(state_q inside {IDLE, DONE});
    assign done        = state_q == DONE;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign empty_start = empty_start_q;
    assign tx_data     = tx_load ? tx_head : '0;
    coax_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_WIDTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .clr(1'b0),
        .wr(host_tx_wr && !busy), .wdata(host_tx_wdata),
        .rd(tx_load), .rdata(tx_head), .full(host_tx_full), .empty(tx_empty)
    );
    coax_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_WIDTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .clr(rx_clr),
        .wr(rx_push), .wdata(rx_data),
        .rd(host_rx_rd), .rdata(host_rx_rdata), .full(rx_full), .empty(host_rx_empty)
    );
    // next state and strobes; strobes are gated by reset so an abort issues nothing further
    always_comb begin
        state_d       = state_q;
        seen_d        = seen_q;
        timeout_d     = timeout_q;
        overflow_d    = overflow_q;
        empty_start_d = empty_start_q;
        rx_clr        = 1'b0;
        rx_push       = 1'b0;
        tx_load       = 1'b0;
        rx_data_read  = 1'b0;
        cnt_d         = state_q == RX_WAIT ? cnt_q + 1'b1 : '0;
        case (state_q)
            IDLE: begin
                if (host_start && tx_empty) begin
                    empty_start_d = 1'b1;
                    state_d       = DONE;
                end else if (host_start) begin
                    timeout_d     = 1'b0;
                    overflow_d    = 1'b0;
                    empty_start_d = 1'b0;
                    seen_d        = 1'b0;
                    rx_clr        = 1'b1;
                    state_d       = TX_LOAD;
                end
            end
            TX_LOAD: begin
                tx_load = !tx_empty && !tx_full && !load_prev_q && !reset;
                seen_d  = seen_q || tx_active;
                state_d = tx_empty ? TX_DRAIN : TX_LOAD;
            end
            TX_DRAIN: begin
                seen_d  = seen_q || tx_active;
                state_d = seen_q && !tx_active && !tx_full ? RX_WAIT : TX_DRAIN;
            end
            RX_WAIT: begin
                if (rx_active || rx_data_available) begin
                    state_d = RX_RECV;
                end else if (cnt_q == CW'(RESPONSE_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            RX_RECV: begin
                rx_data_read = rx_data_available && !rd_prev_q && !reset;
                rx_push      = rx_data_read && (!rx_full || host_rx_rd);
                overflow_d   = overflow_q || (rx_data_read && rx_full && !host_rx_rd);
                state_d      = !rx_active && !rx_data_available && !rx_data_read ? DONE : RX_RECV;
            end
            default: state_d = IDLE;
        endcase
    end
    // state, flags and strobe history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            seen_q        <= 1'b0;
            cnt_q         <= '0;
            load_prev_q   <= 1'b0;
            rd_prev_q     <= 1'b0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            empty_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            seen_q        <= seen_d;
            cnt_q         <= cnt_d;
            load_prev_q   <= tx_load;
            rd_prev_q     <= rx_data_read;
            timeout_q     <= timeout_d;
            overflow_q    <= overflow_d;
            empty_start_q <= empty_start_d;
        end
    end
endmodule

// File: tb/tb_coax_xfer_ctrl.sv
// tb_coax_xfer_ctrl: scoreboard bench with coax_tx/coax_rx stubs around coax_xfer_ctrl
module tb_coax_xfer_ctrl;
    localparam int DEPTH = 4;
    localparam int RT    = 1100;
    logic       clk = 1'b0;
    logic       reset, host_tx_wr, host_start, host_rx_rd;
    logic [9:0] host_tx_wdata, host_rx_rdata, tx_data, rx_data;
    logic       host_tx_full, host_rx_empty, busy, done, timeout, overflow, empty_start;
    logic       tx_load, tx_full, tx_active, rx_active, rx_data_available, rx_data_read;
    int         checks = 0, failures = 0;
    int         n_load = 0, n_rdr = 0, n_done = 0;
    logic [9:0] exp_tx[$], exp_rx[$], rxq[$];
    logic [2:0] exp_done[$];
    bit         rx_go = 1'b0, prev_load = 1'b0;

    always #5 clk = ~clk;

    coax_xfer_ctrl #(.FIFO_DEPTH(DEPTH), .RESPONSE_TIMEOUT(RT)) dut (
        .clk(clk), .reset(reset),
        .host_tx_wr(host_tx_wr), .host_tx_wdata(host_tx_wdata), .host_tx_full(host_tx_full),
        .host_start(host_start), .host_rx_rd(host_rx_rd), .host_rx_rdata(host_rx_rdata),
        .host_rx_empty(host_rx_empty), .busy(busy), .done(done), .timeout(timeout),
        .overflow(overflow), .empty_start(empty_start), .tx_load(tx_load), .tx_data(tx_data),
        .tx_full(tx_full), .tx_active(tx_active), .rx_active(rx_active), .rx_data(rx_data),
        .rx_data_available(rx_data_available), .rx_data_read(rx_data_read)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // coax_tx stub: full for 3 cycles after each load, active across the frame
    initial begin
        int  full_cnt = 0, act_cnt = 0;
        bit  ld;
        tx_full   = 1'b0;
        tx_active = 1'b0;
        forever begin
            @(negedge clk);
            ld = tx_load;
            tick();
            if (ld) begin
                full_cnt = 3;
                act_cnt  = 8;
            end else begin
                if (full_cnt > 0) full_cnt--;
                if (act_cnt > 0) act_cnt--;
            end
            tx_full   = full_cnt != 0;
            tx_active = act_cnt != 0;
        end
    end

    // coax_rx stub: presents queued words, drops available for a cycle after each read
    initial begin
        int tail = 0;
        bit rdr;
        rx_active         = 1'b0;
        rx_data_available = 1'b0;
        rx_data           = '0;
        forever begin
            @(negedge clk);
            rdr = rx_data_read;
            tick();
            if (rdr && rxq.size() != 0) begin
                void'(rxq.pop_front());
                tail              = 2;
                rx_data_available = 1'b0;
            end else begin
                if (tail > 0) tail--;
                rx_data_available = rx_go && rxq.size() != 0;
            end
            if (rx_data_available) rx_data = rxq[0];
            rx_active = (rx_go && rxq.size() != 0) || tail > 0;
        end
    end

    // monitor: pops expected values whenever the DUT presents a load, done or host read
    initial begin
        forever begin
            @(negedge clk);
            if (tx_load) begin
                n_load++;
                chk("load_spacing", prev_load, 0);
                chk("tx_sb_nonempty", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) chk("tx_data", tx_data, exp_tx.pop_front());
            end
            prev_load = tx_load;
            if (rx_data_read) n_rdr++;
            if (done) begin
                n_done++;
                chk("done_sb_nonempty", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) chk("done_flags", {timeout, overflow, empty_start}, exp_done.pop_front());
            end
            if (host_rx_rd && !host_rx_empty) begin
                chk("rx_sb_nonempty", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) chk("rx_rdata", host_rx_rdata, exp_rx.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [9:0] w);
        host_tx_wr    = 1'b1;
        host_tx_wdata = w;
        tick();
        host_tx_wr = 1'b0;
    endtask

    task automatic start();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        chk("done_seen", done, 1);
    endtask

    task automatic wait_tx_end(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_active) seen = 1'b1;
            else if (seen && !tx_full) break;
        end
        chk({tag, "_tx_end"}, seen && !tx_active && !tx_full, 1);
    endtask

    task automatic read_n(input string tag, input int n);
        host_rx_rd = 1'b1;
        repeat (n) tick();
        host_rx_rd = 1'b0;
        chk({tag, "_rx_empty"}, host_rx_empty, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx_load"}, tx_load, 0);
        chk({tag, "_rx_data_read"}, rx_data_read, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_flags"}, {timeout, overflow, empty_start}, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_host_tx_full"}, host_tx_full, 0);
        chk({tag, "_host_rx_empty"}, host_rx_empty, 1);
    endtask

    initial begin
        int k, bl, br, bd, c;
        reset         = 1'b1;
        host_tx_wr    = 1'b0;
        host_tx_wdata = '0;
        host_start    = 1'b0;
        host_rx_rd    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        tick();
        reset = 1'b0;
        tick();

        // normal transaction: 3 command words, 2 response words
        bl = n_load; br = n_rdr; bd = n_done;
        write_word(10'h101); exp_tx.push_back(10'h101);
        write_word(10'h002); exp_tx.push_back(10'h002);
        write_word(10'h3FF); exp_tx.push_back(10'h3FF);
        rxq.push_back(10'h0A5); exp_rx.push_back(10'h0A5);
        rxq.push_back(10'h15A); exp_rx.push_back(10'h15A);
        exp_done.push_back(3'b000);
        start();
        wait_tx_end("t1");
        chk("t1_loads", n_load - bl, 3);
        chk("t1_busy_after_tx", busy, 1);
        rx_go = 1'b1;
        wait_done(500, k);
        rx_go = 1'b0;
        tick();
        @(negedge clk);
        chk("t1_done_one_cycle", done, 0);
        chk("t1_done_count", n_done - bd, 1);
        chk("t1_rx_reads", n_rdr - br, 2);
        tick();
        read_n("t1", 2);
        repeat (12) tick();

        // start with empty TX FIFO
        bl = n_load; bd = n_done;
        exp_done.push_back(3'b001);
        start();
        wait_done(10, k);
        chk("t4_done_latency", k, 1);
        tick();
        chk("t4_no_load", n_load - bl, 0);
        chk("t4_done_count", n_done - bd, 1);
        repeat (3) tick();

        // no response: timeout; a start and a write while busy are ignored
        bl = n_load; br = n_rdr; bd = n_done;
        write_word(10'h155); exp_tx.push_back(10'h155);
        exp_done.push_back(3'b100);
        start();
        tick();
        host_start    = 1'b1;
        host_tx_wr    = 1'b1;
        host_tx_wdata = 10'h2AB;
        tick();
        host_start = 1'b0;
        host_tx_wr = 1'b0;
        wait_tx_end("t2");
        wait_done(RT + 50, k);
        chk("t2_timeout_latency", k, RT + 1);
        tick();
        chk("t2_done_count", n_done - bd, 1);
        chk("t2_loads", n_load - bl, 1);
        chk("t2_rx_reads", n_rdr - br, 0);
        chk("t2_rx_empty", host_rx_empty, 1);
        repeat (12) tick();

        // full TX FIFO, then 6-word response into a 4-deep RX FIFO with no host reads
        bl = n_load; br = n_rdr; bd = n_done;
        write_word(10'h011); exp_tx.push_back(10'h011);
        write_word(10'h022); exp_tx.push_back(10'h022);
        write_word(10'h033); exp_tx.push_back(10'h033);
        write_word(10'h044); exp_tx.push_back(10'h044);
        chk("t3_tx_full", host_tx_full, 1);
        write_word(10'h3AA);
        chk("t3_tx_full_hold", host_tx_full, 1);
        for (int i = 1; i <= 6; i++) begin
            rxq.push_back(10'h300 + 10'(i));
            if (i <= DEPTH) exp_rx.push_back(10'h300 + 10'(i));
        end
        exp_done.push_back(3'b010);
        start();
        wait_tx_end("t3");
        chk("t3_loads", n_load - bl, 4);
        rx_go = 1'b1;
        wait_done(500, k);
        rx_go = 1'b0;
        tick();
        chk("t3_rx_reads", n_rdr - br, 6);
        chk("t3_done_count", n_done - bd, 1);
        read_n("t3", DEPTH);
        repeat (12) tick();

        // reset mid-TX_LOAD with 2 words still queued
        bl = n_load; bd = n_done;
        write_word(10'h0F1); exp_tx.push_back(10'h0F1);
        write_word(10'h0F2); exp_tx.push_back(10'h0F2);
        write_word(10'h0F3);
        write_word(10'h0F4);
        start();
        c = 0;
        for (int i = 0; i < 100 && c < 2; i++) begin
            @(negedge clk);
            if (tx_load) c++;
        end
        chk("t6_two_loads_seen", c, 2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_idle("t6");
        repeat (20) tick();
        chk("t6_no_more_loads", n_load - bl, 2);
        chk("t6_no_done", n_done - bd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coax_xfer_ctrl.md
Name: coax_xfer_ctrl

Overview:
- Transaction sequencer between a host (MCU-side) word interface and the coax_tx / coax_rx pair, all on the 19 MHz PLL clock.
- Host queues a command frame of 10-bit words, then pulses start.
- Block feeds words to coax_tx using its load/full handshake and waits for the line to go idle. It then enables reception, captures response words into a readable buffer or times out, and reports status.
- Replaces the direct host drive of tx_load / rx_data_read and the shared-bus rx_enable steering.

Parameters:
- FIFO_DEPTH, 16, entries in each of TX and RX word FIFOs; power of 2, at least 2.
- RESPONSE_TIMEOUT, 1100, clk cycles allowed from end of transmit to first response activity.

Ports:
- clk  input  1  system clock (19 MHz domain)
- reset  input  1  synchronous, active-high reset
- host_tx_wr  input  1  push host_tx_wdata into TX FIFO
- host_tx_wdata  input  10  command word
- host_tx_full  output  1  TX FIFO full
- host_start  input  1  begin transaction (single-cycle pulse)
- host_rx_rd  input  1  pop RX FIFO head
- host_rx_rdata  output  10  RX FIFO head word (valid when !host_rx_empty)
- host_rx_empty  output  1  RX FIFO empty
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at transaction end
- timeout  output  1  sticky: no response within RESPONSE_TIMEOUT
- overflow  output  1  sticky: response word dropped, RX FIFO full
- empty_start  output  1  sticky: start issued with empty TX FIFO
- tx_load  output  1  load strobe to coax_tx
- tx_data  output  10  word to coax_tx
- tx_full  input  1  coax_tx holding register full
- tx_active  input  1  coax_tx transmitting
- rx_active  input  1  coax_rx receiving
- rx_data  input  10  coax_rx word
- rx_data_available  input  1  coax_rx word pending
- rx_data_read  output  1  acknowledge strobe to coax_rx

Behaviour:
- Reset:
  - state IDLE; both FIFOs empty.
  - tx_load, rx_data_read, busy, done, timeout, overflow, empty_start all 0; tx_data 0.
  - Reset mid-transaction aborts immediately. No further tx_load is issued; a word coax_tx already holds is not recalled.
- FIFOs:
  - Synchronous, first-word-fall-through.
  - Write ignored when full; read ignored when empty. Simultaneous read and write while full or empty is legal, and count stays consistent.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
  - host_tx_wr ignored while busy.
  - RX FIFO cleared on an accepted start.
- IDLE:
  - host_start with TX FIFO non-empty: clear sticky flags and RX FIFO, busy=1, go to TX_LOAD.
  - host_start with TX FIFO empty: empty_start=1, go to DONE; no coax activity.
  - host_start while busy is ignored.
- TX_LOAD:
  - When TX FIFO non-empty, !tx_full, and no load was issued in the previous cycle: drive tx_load=1 for one cycle with tx_data = FIFO head, and pop.
  - Minimum spacing between loads is 2 cycles, because coax_tx full updates a cycle late.
  - Go to TX_DRAIN when the FIFO is empty and no load is issued this cycle.
  - seen_active is set on any cycle with tx_active=1 in TX_LOAD or TX_DRAIN.
- TX_DRAIN:
  - Go to RX_WAIT when seen_active=1, tx_active=0 and tx_full=0.
  - Timeout counter cleared on entry to RX_WAIT.
- RX_WAIT:
  - Counter increments each cycle.
  - rx_active=1 or rx_data_available=1: go to RX_RECV. Data available in the same cycle is handled in RX_RECV on the next cycle.
  - Counter == RESPONSE_TIMEOUT-1 with no activity: timeout=1, go to DONE.
  - Activity takes priority over timeout in the same cycle.
- RX_RECV:
  - rx_data_available=1 and no rx_data_read in the previous cycle: pulse rx_data_read.
    - If RX FIFO has space (space check includes a same-cycle host_rx_rd pop), push rx_data.
    - Otherwise drop the word and set overflow=1.
  - rx_active=0 and rx_data_available=0 and no read pulse this cycle: go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE. Sticky flags hold until the next accepted start.
- busy=1 in every state except IDLE and DONE.

Decomposition:
- Shared package coax_ctrl_pkg:
  - state enum (IDLE, TX_LOAD, TX_DRAIN, RX_WAIT, RX_RECV, DONE)
  - WORD_WIDTH=10
  - default FIFO_DEPTH and RESPONSE_TIMEOUT
- One sub-module, coax_word_fifo (parameterised depth and width), instantiated twice, for TX and RX.

Test Plan:
- Write 0x101, 0x002, 0x3FF, then start; stub coax_tx pulses full for 3 cycles per load and tx_active over the frame:
  - exactly 3 tx_load pulses, tx_data in that order, never 2 loads in consecutive cycles;
  - block then enters RX_WAIT.
- After TX, stub coax_rx presents 0x0A5, 0x15A, with rx_active spanning both:
  - 2 rx_data_read pulses;
  - host reads 0x0A5 then 0x15A;
  - done pulses once; timeout=0, overflow=0.
- After TX, no rx activity:
  - timeout=1 and done exactly RESPONSE_TIMEOUT+1 cycles after RX_WAIT entry;
  - RX FIFO empty.
- FIFO_DEPTH=4, response of 6 words, host not reading:
  - 4 words stored, 6 rx_data_read pulses, overflow=1;
  - stored words are the first 4.
- start with empty TX FIFO: done next cycle, empty_start=1, no tx_load.
- start while busy is ignored.
- Assert reset mid-TX_LOAD with 2 words remaining:
  - outputs return to reset values the next cycle;
  - no further tx_load;
  - host_tx_full=0, host_rx_empty=1.
